// File: rtl/ct_had_sqc_if.sv
// ----------------------------------------------------------------------------
// ct_had_sqc_if
// Bus bundle for the HAD memory-breakpoint sequence-condition stage: level-three
// requests from units A/B, HCR controls, core status and the debug request out.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ct_had_sqc_if #(
  parameter int WIN_W = 8
);
  logic             bkpta_ctrl_inst_req;
  logic             bkpta_ctrl_data_req;
  logic             bkptb_ctrl_inst_req;
  logic             bkptb_ctrl_data_req;
  logic [1:0]       regs_xx_sqc;
  logic [WIN_W-1:0] regs_xx_sqc_win;
  logic             ctrl_bkpt_en;
  logic             rtu_yy_xx_retire0_normal;
  logic             rtu_yy_xx_dbgon;
  logic             x_sm_xx_update_dr_en;
  logic             ir_xx_hcr_reg_sel;
  logic             sqc_ctrl_mbkpt_req;
  logic [1:0]       sqc_ctrl_mbkpt_src;
  logic             sqc_regs_armed;
  logic [1:0]       sqc_regs_hit;

  // Sequence-condition stage side
  modport slave (
    input  bkpta_ctrl_inst_req, bkpta_ctrl_data_req,
    input  bkptb_ctrl_inst_req, bkptb_ctrl_data_req,
    input  regs_xx_sqc, regs_xx_sqc_win, ctrl_bkpt_en,
    input  rtu_yy_xx_retire0_normal, rtu_yy_xx_dbgon,
    input  x_sm_xx_update_dr_en, ir_xx_hcr_reg_sel,
    output sqc_ctrl_mbkpt_req, sqc_ctrl_mbkpt_src, sqc_regs_armed, sqc_regs_hit
  );

  // Driver side (breakpoint units, registers, RTU)
  modport master (
    output bkpta_ctrl_inst_req, bkpta_ctrl_data_req,
    output bkptb_ctrl_inst_req, bkptb_ctrl_data_req,
    output regs_xx_sqc, regs_xx_sqc_win, ctrl_bkpt_en,
    output rtu_yy_xx_retire0_normal, rtu_yy_xx_dbgon,
    output x_sm_xx_update_dr_en, ir_xx_hcr_reg_sel,
    input  sqc_ctrl_mbkpt_req, sqc_ctrl_mbkpt_src, sqc_regs_armed, sqc_regs_hit
  );
endinterface

`default_nettype wire

// File: rtl/ct_had_sqc.sv
// ----------------------------------------------------------------------------
// ct_had_sqc
// Level-four memory breakpoint stage: applies the HCR sequence condition to the
// A/B unit requests, with an optional retirement window, and holds one debug
// request (with source) until the core enters debug mode.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ct_had_sqc #(
  parameter int WIN_W = 8
) (
  input  wire logic   cpuclk,
  input  wire logic   cpurst_b,
  ct_had_sqc_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2
  } state_e;

  localparam logic [WIN_W-1:0] WIN_ZERO = '0;
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       hit_q, hit_d;

  logic       hit_a, hit_b;
  logic       first_hit, second_hit;
  logic       ordered_mode;
  logic       clr;
  logic [1:0] mode;

  // Qualify unit requests and map them onto first/second roles for the current mode
  always_comb begin
    mode         = bus.regs_xx_sqc;
    hit_a        = (bus.bkpta_ctrl_inst_req | bus.bkpta_ctrl_data_req)
                   & bus.ctrl_bkpt_en & ~bus.rtu_yy_xx_dbgon;
    hit_b        = (bus.bkptb_ctrl_inst_req | bus.bkptb_ctrl_data_req)
                   & bus.ctrl_bkpt_en & ~bus.rtu_yy_xx_dbgon;
    ordered_mode = (mode == 2'b01) || (mode == 2'b10);
    first_hit    = (mode == 2'b10) ? hit_b : hit_a;
    second_hit   = (mode == 2'b10) ? hit_a : hit_b;
    clr          = bus.x_sm_xx_update_dr_en & bus.ir_xx_hcr_reg_sel;
  end

  // Next-state logic: sequence FSM, window counter, source and sticky hit status
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    src_d     = src_q;
    // A new hit outranks the HCR clear in the same cycle
    hit_d     = (clr ? 2'b00 : hit_q) | {hit_a, hit_b};

    if (clr) begin
      state_d   = ST_IDLE;
      win_cnt_d = WIN_ZERO;
      src_d     = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mode == 2'b00) begin
            if (hit_a | hit_b) begin
              state_d = ST_REQ;
              src_d   = {hit_a, hit_b};
            end
          end else if (mode == 2'b11) begin
            if (hit_a & hit_b) begin
              state_d = ST_REQ;
              src_d   = 2'b11;
            end
          end else if (first_hit) begin
            // A coincident second event does not count; it must come later
            state_d   = ST_ARMED;
            win_cnt_d = bus.regs_xx_sqc_win;
          end
        end
        ST_ARMED: begin
          if (!bus.ctrl_bkpt_en || !ordered_mode) begin
            state_d = ST_IDLE;
          end else if (second_hit) begin
            state_d = ST_REQ;
            src_d   = 2'b11;
          end else if (first_hit) begin
            win_cnt_d = bus.regs_xx_sqc_win;
          end else if ((bus.regs_xx_sqc_win != WIN_ZERO) && bus.rtu_yy_xx_retire0_normal) begin
            if (win_cnt_q == WIN_ONE) begin
              state_d = ST_IDLE;
            end else if (win_cnt_q != WIN_ZERO) begin
              win_cnt_d = win_cnt_q - WIN_ONE;
            end
          end
        end
        ST_REQ: begin
          if (bus.rtu_yy_xx_dbgon) begin
            state_d = ST_IDLE;
            src_d   = 2'b00;
          end
        end
        default: begin
          state_d = ST_IDLE;
          src_d   = 2'b00;
        end
      endcase
    end
  end

  // State registers, cleared asynchronously by core reset
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= WIN_ZERO;
      src_q     <= 2'b00;
      hit_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      src_q     <= src_d;
      hit_q     <= hit_d;
    end
  end

  assign bus.sqc_ctrl_mbkpt_req = (state_q == ST_REQ);
  assign bus.sqc_ctrl_mbkpt_src = src_q;
  assign bus.sqc_regs_armed     = (state_q == ST_ARMED);
  assign bus.sqc_regs_hit       = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_ct_had_sqc.sv
// ----------------------------------------------------------------------------
// tb_ct_had_sqc
// Directed scenario tasks plus a randomized run against a behavioural model of
// the sequence-condition rules.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ct_had_sqc;

  logic cpuclk;
  logic cpurst_b;
  int   n_checks;
  int   n_fail;

  // Behavioural model: request/armed flags plus a count of retirements since
  // the newest first event
  bit       m_req;
  bit       m_armed;
  bit [1:0] m_src;
  bit [1:0] m_hit;
  int       m_rets;

  ct_had_sqc_if #(.WIN_W(8)) bus ();

  ct_had_sqc #(.WIN_W(8)) u_dut (
    .cpuclk   (cpuclk),
    .cpurst_b (cpurst_b),
    .bus      (bus)
  );

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  task automatic model_reset();
    m_req = 0; m_armed = 0; m_src = 2'b00; m_hit = 2'b00; m_rets = 0;
  endtask

  task automatic model_step();
    bit ha, hb, fst, snd, clr, en;
    int mode, win;
    en   = bus.ctrl_bkpt_en;
    ha   = (bus.bkpta_ctrl_inst_req || bus.bkpta_ctrl_data_req) && en && !bus.rtu_yy_xx_dbgon;
    hb   = (bus.bkptb_ctrl_inst_req || bus.bkptb_ctrl_data_req) && en && !bus.rtu_yy_xx_dbgon;
    mode = int'(bus.regs_xx_sqc);
    win  = int'(bus.regs_xx_sqc_win);
    fst  = (mode == 2) ? hb : ha;
    snd  = (mode == 2) ? ha : hb;
    clr  = bus.x_sm_xx_update_dr_en && bus.ir_xx_hcr_reg_sel;
    m_hit = (clr ? 2'b00 : m_hit) | {ha, hb};
    if (clr) begin
      m_req = 0; m_armed = 0; m_src = 2'b00;
    end else if (m_req) begin
      if (bus.rtu_yy_xx_dbgon) begin
        m_req = 0; m_src = 2'b00;
      end
    end else if (m_armed) begin
      if (!en || mode == 0 || mode == 3) m_armed = 0;
      else if (snd) begin
        m_armed = 0; m_req = 1; m_src = 2'b11;
      end else if (fst) m_rets = 0;
      else if (win != 0 && bus.rtu_yy_xx_retire0_normal) begin
        m_rets++;
        if (m_rets >= win) m_armed = 0;
      end
    end else begin
      if (mode == 0 && (ha || hb)) begin
        m_req = 1; m_src = {ha, hb};
      end else if (mode == 3 && ha && hb) begin
        m_req = 1; m_src = 2'b11;
      end else if ((mode == 1 || mode == 2) && fst) begin
        m_armed = 1; m_rets = 0;
      end
    end
  endtask

  // Advance n cycles; outputs are sampled 1 ns after each rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge cpuclk);
      #1;
    end
  endtask

  task automatic drive_quiet();
    bus.bkpta_ctrl_inst_req = 0; bus.bkpta_ctrl_data_req = 0;
    bus.bkptb_ctrl_inst_req = 0; bus.bkptb_ctrl_data_req = 0;
    bus.rtu_yy_xx_retire0_normal = 0; bus.rtu_yy_xx_dbgon = 0;
    bus.x_sm_xx_update_dr_en = 0; bus.ir_xx_hcr_reg_sel = 0;
    bus.ctrl_bkpt_en = 1;
  endtask

  task automatic hcr_write();
    bus.x_sm_xx_update_dr_en = 1; bus.ir_xx_hcr_reg_sel = 1;
    tick(1);
    bus.x_sm_xx_update_dr_en = 0; bus.ir_xx_hcr_reg_sel = 0;
  endtask

  task automatic leave_req();
    bus.rtu_yy_xx_dbgon = 1; tick(1); bus.rtu_yy_xx_dbgon = 0;
  endtask

  task automatic test_reset();
    drive_quiet();
    bus.regs_xx_sqc = 2'b00; bus.regs_xx_sqc_win = 8'd0;
    cpurst_b = 0;
    repeat (3) @(posedge cpuclk);
    #1;
    n_checks++;
    if ({bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src, bus.sqc_regs_armed, bus.sqc_regs_hit} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b src=%b armed=%b hit=%b, want all zero",
               bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src, bus.sqc_regs_armed, bus.sqc_regs_hit);
    end
    cpurst_b = 1;
    tick(2);
  endtask

  task automatic test_mode00();
    bus.regs_xx_sqc = 2'b00;
    tick(2);
    bus.bkpta_ctrl_inst_req = 1; tick(1); bus.bkpta_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b1 || bus.sqc_ctrl_mbkpt_src !== 2'b10) begin
      n_fail++;
      $display("FAIL mode00_req: got req=%b src=%b, want req=1 src=10", bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src);
    end
    bus.bkptb_ctrl_data_req = 1; tick(3); bus.bkptb_ctrl_data_req = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b1 || bus.sqc_ctrl_mbkpt_src !== 2'b10 || bus.sqc_regs_hit !== 2'b11) begin
      n_fail++;
      $display("FAIL mode00_hold: got req=%b src=%b hit=%b, want req=1 src=10 hit=11",
               bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src, bus.sqc_regs_hit);
    end
    leave_req();
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b0 || bus.sqc_ctrl_mbkpt_src !== 2'b00) begin
      n_fail++;
      $display("FAIL mode00_dbgon: got req=%b src=%b, want req=0 src=00", bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src);
    end
  endtask

  task automatic test_window();
    hcr_write();
    bus.regs_xx_sqc = 2'b01; bus.regs_xx_sqc_win = 8'd3;
    bus.bkpta_ctrl_data_req = 1; tick(1); bus.bkpta_ctrl_data_req = 0;
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b1 || bus.sqc_ctrl_mbkpt_req !== 1'b0) begin
      n_fail++;
      $display("FAIL win_arm: got armed=%b req=%b, want armed=1 req=0", bus.sqc_regs_armed, bus.sqc_ctrl_mbkpt_req);
    end
    bus.rtu_yy_xx_retire0_normal = 1; tick(2); bus.rtu_yy_xx_retire0_normal = 0;
    bus.bkptb_ctrl_inst_req = 1; tick(1); bus.bkptb_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b1 || bus.sqc_ctrl_mbkpt_src !== 2'b11) begin
      n_fail++;
      $display("FAIL win_inside: got req=%b src=%b, want req=1 src=11", bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src);
    end
    leave_req();
    bus.bkpta_ctrl_inst_req = 1; tick(1); bus.bkpta_ctrl_inst_req = 0;
    bus.rtu_yy_xx_retire0_normal = 1; tick(2);
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b1) begin
      n_fail++;
      $display("FAIL win_two_ret: got armed=%b, want 1", bus.sqc_regs_armed);
    end
    tick(1); bus.rtu_yy_xx_retire0_normal = 0;
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b0 || bus.sqc_ctrl_mbkpt_req !== 1'b0) begin
      n_fail++;
      $display("FAIL win_timeout: got armed=%b req=%b, want 0 0", bus.sqc_regs_armed, bus.sqc_ctrl_mbkpt_req);
    end
    // Second event coinciding with the closing retirement still counts
    bus.bkpta_ctrl_inst_req = 1; tick(1); bus.bkpta_ctrl_inst_req = 0;
    bus.rtu_yy_xx_retire0_normal = 1; tick(2);
    bus.bkptb_ctrl_inst_req = 1; tick(1);
    bus.bkptb_ctrl_inst_req = 0; bus.rtu_yy_xx_retire0_normal = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b1) begin
      n_fail++;
      $display("FAIL win_edge_second: got req=%b, want 1", bus.sqc_ctrl_mbkpt_req);
    end
    leave_req();
  endtask

  task automatic test_order();
    bus.regs_xx_sqc = 2'b01; bus.regs_xx_sqc_win = 8'd0;
    bus.bkptb_ctrl_inst_req = 1; tick(1); bus.bkptb_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b0 || bus.sqc_ctrl_mbkpt_req !== 1'b0) begin
      n_fail++;
      $display("FAIL order_second_alone: got armed=%b req=%b, want 0 0", bus.sqc_regs_armed, bus.sqc_ctrl_mbkpt_req);
    end
    bus.bkpta_ctrl_inst_req = 1; bus.bkptb_ctrl_inst_req = 1; tick(1);
    bus.bkpta_ctrl_inst_req = 0; bus.bkptb_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b1 || bus.sqc_ctrl_mbkpt_req !== 1'b0) begin
      n_fail++;
      $display("FAIL order_same_cycle: got armed=%b req=%b, want 1 0", bus.sqc_regs_armed, bus.sqc_ctrl_mbkpt_req);
    end
    tick(2);
    bus.bkptb_ctrl_data_req = 1; tick(1); bus.bkptb_ctrl_data_req = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b1 || bus.sqc_ctrl_mbkpt_src !== 2'b11) begin
      n_fail++;
      $display("FAIL order_later_second: got req=%b src=%b, want 1 11", bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src);
    end
    leave_req();
  endtask

  task automatic test_mode11();
    bus.regs_xx_sqc = 2'b11;
    bus.bkpta_ctrl_inst_req = 1; tick(1); bus.bkpta_ctrl_inst_req = 0;
    bus.bkptb_ctrl_inst_req = 1; tick(1); bus.bkptb_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b0 || bus.sqc_regs_armed !== 1'b0) begin
      n_fail++;
      $display("FAIL mode11_split: got req=%b armed=%b, want 0 0", bus.sqc_ctrl_mbkpt_req, bus.sqc_regs_armed);
    end
    tick(2);
    bus.bkpta_ctrl_data_req = 1; bus.bkptb_ctrl_inst_req = 1; tick(1);
    bus.bkpta_ctrl_data_req = 0; bus.bkptb_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b1 || bus.sqc_ctrl_mbkpt_src !== 2'b11) begin
      n_fail++;
      $display("FAIL mode11_both: got req=%b src=%b, want 1 11", bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src);
    end
    leave_req();
  endtask

  task automatic test_unlimited();
    bus.regs_xx_sqc = 2'b10; bus.regs_xx_sqc_win = 8'd0;
    bus.bkptb_ctrl_inst_req = 1; tick(1); bus.bkptb_ctrl_inst_req = 0;
    bus.rtu_yy_xx_retire0_normal = 1; tick(300); bus.rtu_yy_xx_retire0_normal = 0;
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b1) begin
      n_fail++;
      $display("FAIL unlimited_armed: got armed=%b, want 1", bus.sqc_regs_armed);
    end
    bus.bkpta_ctrl_inst_req = 1; tick(1); bus.bkpta_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b1 || bus.sqc_ctrl_mbkpt_src !== 2'b11) begin
      n_fail++;
      $display("FAIL unlimited_req: got req=%b src=%b, want 1 11", bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src);
    end
    leave_req();
    bus.bkptb_ctrl_inst_req = 1; tick(1); bus.bkptb_ctrl_inst_req = 0;
    hcr_write();
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b0 || bus.sqc_regs_hit !== 2'b00) begin
      n_fail++;
      $display("FAIL hcr_clear: got armed=%b hit=%b, want 0 00", bus.sqc_regs_armed, bus.sqc_regs_hit);
    end
  endtask

  task automatic test_blocked();
    bus.regs_xx_sqc = 2'b00;
    bus.ctrl_bkpt_en = 0; bus.bkpta_ctrl_inst_req = 1; tick(1);
    bus.ctrl_bkpt_en = 1; bus.rtu_yy_xx_dbgon = 1; tick(1);
    bus.rtu_yy_xx_dbgon = 0; bus.bkpta_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b0 || bus.sqc_regs_hit !== 2'b00) begin
      n_fail++;
      $display("FAIL blocked_hits: got req=%b hit=%b, want 0 00", bus.sqc_ctrl_mbkpt_req, bus.sqc_regs_hit);
    end
    bus.regs_xx_sqc = 2'b01; bus.regs_xx_sqc_win = 8'd2;
    bus.bkpta_ctrl_inst_req = 1; tick(1); bus.bkpta_ctrl_inst_req = 0;
    bus.rtu_yy_xx_dbgon = 1; bus.bkptb_ctrl_inst_req = 1; tick(2);
    bus.rtu_yy_xx_dbgon = 0; bus.bkptb_ctrl_inst_req = 0;
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b1 || bus.sqc_ctrl_mbkpt_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dbgon_armed: got armed=%b req=%b, want 1 0", bus.sqc_regs_armed, bus.sqc_ctrl_mbkpt_req);
    end
    bus.ctrl_bkpt_en = 0; tick(1); bus.ctrl_bkpt_en = 1;
    n_checks++;
    if (bus.sqc_regs_armed !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_drop: got armed=%b, want 0", bus.sqc_regs_armed);
    end
  endtask

  task automatic test_reset_mid();
    bus.regs_xx_sqc = 2'b00;
    bus.bkptb_ctrl_inst_req = 1; tick(1); bus.bkptb_ctrl_inst_req = 0;
    #2;
    cpurst_b = 0;
    #1;
    n_checks++;
    if (bus.sqc_ctrl_mbkpt_req !== 1'b0 || bus.sqc_ctrl_mbkpt_src !== 2'b00 || bus.sqc_regs_hit !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_async: got req=%b src=%b hit=%b, want 0 00 00",
               bus.sqc_ctrl_mbkpt_req, bus.sqc_ctrl_mbkpt_src, bus.sqc_regs_hit);
    end
    @(posedge cpuclk); #1;
    cpurst_b = 1;
    tick(1);
  endtask

  task automatic test_random();
    bit [7:0] wins [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5};
    cpurst_b = 0; drive_quiet();
    @(posedge cpuclk); #1;
    cpurst_b = 1;
    model_reset();
    for (int seg = 0; seg < 10; seg++) begin
      bus.regs_xx_sqc     = 2'($urandom_range(0, 3));
      bus.regs_xx_sqc_win = wins[$urandom_range(0, 4)];
      hcr_write();
      for (int c = 0; c < 200; c++) begin
        bus.bkpta_ctrl_inst_req = ($urandom_range(0, 11) == 0);
        bus.bkpta_ctrl_data_req = ($urandom_range(0, 11) == 0);
        bus.bkptb_ctrl_inst_req = ($urandom_range(0, 11) == 0);
        bus.bkptb_ctrl_data_req = ($urandom_range(0, 11) == 0);
        bus.rtu_yy_xx_retire0_normal = $urandom_range(0, 1) == 1;
        bus.rtu_yy_xx_dbgon     = ($urandom_range(0, 19) == 0);
        bus.ctrl_bkpt_en        = ($urandom_range(0, 15) != 0);
        bus.x_sm_xx_update_dr_en = ($urandom_range(0, 15) == 0);
        bus.ir_xx_hcr_reg_sel   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 49) == 0) bus.regs_xx_sqc = 2'($urandom_range(0, 3));
        tick(1);
        n_checks++;
        if (bus.sqc_ctrl_mbkpt_req !== m_req || bus.sqc_regs_armed !== m_armed ||
            bus.sqc_ctrl_mbkpt_src !== m_src || bus.sqc_regs_hit !== m_hit) begin
          n_fail++;
          $display("FAIL random seg%0d cyc%0d: got req=%b armed=%b src=%b hit=%b, want req=%b armed=%b src=%b hit=%b",
                   seg, c, bus.sqc_ctrl_mbkpt_req, bus.sqc_regs_armed, bus.sqc_ctrl_mbkpt_src,
                   bus.sqc_regs_hit, m_req, m_armed, m_src, m_hit);
        end
      end
    end
    drive_quiet();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    test_reset();
    test_mode00();
    test_window();
    test_order();
    test_mode11();
    test_unlimited();
    test_blocked();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
